// File: rtl/dmem_sram_like_bridge_pkg.sv
// Shared definitions for the D-side sram-like bridge: FSM states, transfer sizes
// and the lane-offset helper used when aligning store addresses.
package dmem_sram_like_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Byte lane of the lowest asserted write enable.
  function automatic logic [1:0] low_lane(input logic [3:0] wen);
    if (wen[0])      return 2'd0;
    else if (wen[1]) return 2'd1;
    else if (wen[2]) return 2'd2;
    else             return 2'd3;
  endfunction

endpackage

// File: rtl/dmem_size_decode.sv
// Maps byte write enables onto a bus transfer size and bus address.
// Purely combinational so the I-side bridge can reuse it for loads.
module dmem_size_decode
  import dmem_sram_like_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [3:0]        wen_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [1:0]        size_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              legal_o
);

  // The lane offset comes from the enables, never from the incoming low address bits.
  logic unused_addr_lo;
  assign unused_addr_lo = ^addr_i[1:0];

  always_comb begin
    size_o  = SIZE_WORD;
    addr_o  = {addr_i[ADDR_W-1:2], 2'b00};
    legal_o = 1'b1;
    unique case (wen_i)
      4'b0000, 4'b1111: ;
      4'b0011, 4'b1100: begin
        size_o = SIZE_HALF;
        addr_o = {addr_i[ADDR_W-1:2], low_lane(wen_i)};
      end
      4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
        size_o = SIZE_BYTE;
        addr_o = {addr_i[ADDR_W-1:2], low_lane(wen_i)};
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_sram_like_bridge.sv
// Turns the single-cycle M-stage memory access into one sram-like req/addr_ok/data_ok
// transaction, stalling the pipeline until the response has been taken.
//
// state | meaning
// IDLE  | no access in flight; mem_en launches one
// REQ   | data_req asserted, waiting for addr_ok
// WAIT  | request accepted, waiting for data_ok
// DONE  | access finished; held until the pipeline advances
module dmem_sram_like_bridge
  import dmem_sram_like_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [3:0]        mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              pipe_stall,
  output logic [31:0]       mem_rdata,
  output logic              mem_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
);

  bridge_state_e     state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              launch, capture;

  logic [1:0]        dec_size;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_legal;

  dmem_size_decode #(.ADDR_W(ADDR_W)) u_size_decode (
    .wen_i   (mem_wen),
    .addr_i  (mem_addr),
    .size_o  (dec_size),
    .addr_o  (dec_addr),
    .legal_o (dec_legal)
  );

  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    capture   = 1'b0;
    mem_stall = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_en) begin
          mem_stall = 1'b1;
          launch    = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_stall = 1'b1;
        // data_ok before addr_ok has no request behind it and is dropped.
        if (data_addr_ok) begin
          if (data_data_ok) begin
            capture = ~wr_q;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        mem_stall = 1'b1;
        if (data_data_ok) begin
          capture = ~wr_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!pipe_stall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_d    = launch  ? (mem_wen != 4'b0000) : wr_q;
  assign size_d  = launch  ? dec_size             : size_q;
  assign addr_d  = launch  ? dec_addr             : addr_q;
  assign wdata_d = launch  ? mem_wdata            : wdata_q;
  assign rdata_d = capture ? data_rdata           : rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_req   = (state_q == ST_REQ);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign mem_rdata  = rdata_q;

  a_legal_wen: assert property (@(posedge clk) disable iff (!rst)
    (state_q == ST_IDLE && mem_en) |-> dec_legal);

endmodule
